// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with a run-time selectable test-pattern source for a TMDS encoder.
// Latency: every output is registered one pixel_clk after the hc/vc value it decodes.
// Backpressure: none; runs freely while en is high, en low holds the restart state.
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 12
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       pattern_sel,
    input  logic [23:0]      solid_rgb,
    output logic             hsync,
    output logic             vsync,
    output logic             vde,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W     = H_ACTIVE / 8;
    localparam int MBAR_W    = 16;
    localparam int MBAR_STEP = 4;

    // Counter-width copies of the timing boundaries so every compare is width-matched.
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'(BAR_W - 1);

    // One extra bit so bar_pos + width / step cannot overflow near the line end.
    localparam logic [CNT_W:0]   MBAR_W_X  = (CNT_W + 1)'(MBAR_W);
    localparam logic [CNT_W:0]   STEP_X    = (CNT_W + 1)'(MBAR_STEP);
    localparam logic [CNT_W:0]   H_ACT_X   = (CNT_W + 1)'(H_ACTIVE);

    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BLACK   = 24'h000000;
    localparam logic [23:0] GRID_BG = 24'h202020;
    localparam logic [23:0] MBAR_BG = 24'h000040;

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic [CNT_W-1:0] bar_sub;
    logic [2:0]       bar_idx;
    logic [2:0]       pat_q;
    logic [CNT_W-1:0] bar_pos;

    logic             h_last;
    logic             v_last;
    logic             frame_wrap;
    logic             frame_first;
    logic             active;
    logic             hs_on;
    logic             vs_on;
    logic             in_mbar;
    logic [2:0]       pat_cur;
    logic [CNT_W:0]   mbar_end;
    logic [CNT_W:0]   bar_pos_inc;
    logic [23:0]      pix_rgb;

    // Standard colour-bar order, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    assign h_last      = (hc == H_LAST);
    assign v_last      = (vc == V_LAST);
    assign frame_wrap  = h_last && v_last;
    assign frame_first = (hc == '0) && (vc == '0);
    assign active      = (hc < H_ACT_END) && (vc < V_ACT_END);
    assign hs_on       = (hc >= HS_BEGIN) && (hc < HS_END);
    assign vs_on       = (vc >= VS_BEGIN) && (vc < VS_END);

    // The first pixel of a frame already uses the freshly sampled mode, so a whole frame is one mode.
    assign pat_cur     = frame_first ? pattern_sel : pat_q;

    assign mbar_end    = {1'b0, bar_pos} + MBAR_W_X;
    assign in_mbar     = (hc >= bar_pos) && ({1'b0, hc} < mbar_end);
    assign bar_pos_inc = {1'b0, bar_pos} + STEP_X;

    // Pixel colour for the current counter position, per active pattern mode.
    always_comb begin
        pix_rgb = BLACK;
        case (pat_cur)
            3'd0:    pix_rgb = bar_colour(bar_idx);
            3'd1:    pix_rgb = {hc[7:0], vc[7:0], hc[7:0] ^ vc[7:0]};
            3'd2:    pix_rgb = (hc[5] ^ vc[5]) ? WHITE : BLACK;
            3'd3:    pix_rgb = solid_rgb;
            3'd4:    pix_rgb = ((hc[5:0] == 6'd0) || (vc[5:0] == 6'd0)) ? WHITE : GRID_BG;
            3'd5:    pix_rgb = in_mbar ? WHITE : MBAR_BG;
            default: pix_rgb = BLACK;
        endcase
    end

    // Horizontal/vertical raster counters; en low parks them at the origin.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (!en) begin
            hc <= '0;
            vc <= '0;
        end else if (h_last) begin
            hc <= '0;
            vc <= v_last ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    // Colour-bar index tracks hc/BAR_W with a per-line sub-counter instead of a divider.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            bar_sub <= '0;
            bar_idx <= '0;
        end else if (!en || h_last) begin
            bar_sub <= '0;
            bar_idx <= '0;
        end else if (bar_sub == BAR_LAST) begin
            bar_sub <= '0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_sub <= bar_sub + 1'b1;
        end
    end

    // Per-frame state: latched pattern mode, moving-bar position and completed-frame count.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pat_q     <= '0;
            bar_pos   <= '0;
            frame_cnt <= '0;
        end else if (!en) begin
            pat_q     <= '0;
            bar_pos   <= '0;
            frame_cnt <= '0;
        end else begin
            if (frame_first) begin
                pat_q <= pattern_sel;
            end
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
                bar_pos   <= (bar_pos_inc >= H_ACT_X) ? '0 : bar_pos_inc[CNT_W-1:0];
            end
        end
    end

    // Output register: all video outputs aligned one cycle behind the counters.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            vde         <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            vde         <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync               <= hs_on ? HS_POL : ~HS_POL;
            vsync               <= vs_on ? VS_POL : ~VS_POL;
            vde                 <= active;
            {red, green, blue}  <= active ? pix_rgb : BLACK;
            x                   <= hc;
            y                   <= vc;
            frame_start         <= active && frame_first;
        end
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen: two small configurations (active-low and active-high syncs)
// driven with shared randomized stimulus and compared every cycle against a position-based model.
// Model outputs derive from the cycle index since restart, not from counter state machines.
module tb_video_timing_pattern_gen;

    localparam int NI = 2;
    localparam int HA [NI] = '{64, 16};
    localparam int HF [NI] = '{4, 1};
    localparam int HS [NI] = '{8, 2};
    localparam int HB [NI] = '{4, 1};
    localparam int VA [NI] = '{8, 4};
    localparam int VF [NI] = '{1, 1};
    localparam int VS [NI] = '{1, 1};
    localparam int VB [NI] = '{1, 1};
    localparam bit HP [NI] = '{1'b0, 1'b1};
    localparam bit VP [NI] = '{1'b0, 1'b1};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vde;
        logic [23:0] rgb;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [2:0]  sel = 3'd0;
    logic [23:0] solid = 24'h123456;

    logic        hs_a, vs_a, vde_a, fs_a, hs_b, vs_b, vde_b, fs_b;
    logic [7:0]  r_a, g_a, b_a, fc_a, r_b, g_b, b_b, fc_b;
    logic [11:0] x_a, y_a, x_b, y_b;
    obs_t        obs_a, obs_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    video_timing_pattern_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
    ) dut_a (
        .pixel_clk(clk), .reset(rst), .en(en), .pattern_sel(sel), .solid_rgb(solid),
        .hsync(hs_a), .vsync(vs_a), .vde(vde_a), .red(r_a), .green(g_a), .blue(b_a),
        .x(x_a), .y(y_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    video_timing_pattern_gen #(
        .H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12)
    ) dut_b (
        .pixel_clk(clk), .reset(rst), .en(en), .pattern_sel(sel), .solid_rgb(solid),
        .hsync(hs_b), .vsync(vs_b), .vde(vde_b), .red(r_b), .green(g_b), .blue(b_b),
        .x(x_b), .y(y_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    assign obs_a = {hs_a, vs_a, vde_a, r_a, g_a, b_a, x_a, y_a, fs_a, fc_a};
    assign obs_b = {hs_b, vs_b, vde_b, r_b, g_b, b_b, x_b, y_b, fs_b, fc_b};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          j   [NI] = '{-1, -1};
    int          bar [NI] = '{0, 0};
    logic [2:0]  pat [NI] = '{3'd0, 3'd0};
    obs_t        expv [NI];

    function automatic obs_t idle_obs(input int k);
        obs_t o;
        o = '0;
        o.hs = !HP[k];
        o.vs = !VP[k];
        return o;
    endfunction

    function automatic logic [23:0] colour(input int k, input logic [2:0] p, input int h, input int v,
                                           input int bp, input logic [23:0] s);
        case (p)
            3'd0: begin
                case (h / (HA[k] / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            3'd1: return {8'(h), 8'(v), 8'(h ^ v)};
            3'd2: return (((h / 32) + (v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            3'd3: return s;
            3'd4: return ((h % 64 == 0) || (v % 64 == 0)) ? 24'hFFFFFF : 24'h202020;
            3'd5: return ((h >= bp) && (h < bp + 16)) ? 24'hFFFFFF : 24'h000040;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic model_step(input int k);
        int ht, vt, ft, pos, h, v;
        bit act;
        ht = HA[k] + HF[k] + HS[k] + HB[k];
        vt = VA[k] + VF[k] + VS[k] + VB[k];
        ft = ht * vt;
        if (rst || !en) begin
            j[k]    = -1;
            bar[k]  = 0;
            pat[k]  = 3'd0;
            expv[k] = idle_obs(k);
        end else begin
            j[k] = j[k] + 1;
            pos  = j[k] % ft;
            h    = pos % ht;
            v    = pos / ht;
            if (pos == 0) begin
                pat[k] = sel;
                if (j[k] > 0) begin
                    bar[k] = bar[k] + 4;
                    if (bar[k] >= HA[k]) bar[k] = 0;
                end
            end
            act          = (h < HA[k]) && (v < VA[k]);
            expv[k].hs   = (h >= HA[k] + HF[k] && h < HA[k] + HF[k] + HS[k]) ? HP[k] : !HP[k];
            expv[k].vs   = (v >= VA[k] + VF[k] && v < VA[k] + VF[k] + VS[k]) ? VP[k] : !VP[k];
            expv[k].vde  = act;
            expv[k].rgb  = act ? colour(k, pat[k], h, v, bar[k], solid) : 24'h0;
            expv[k].x    = 12'(h);
            expv[k].y    = 12'(v);
            expv[k].fs   = (pos == 0);
            expv[k].fc   = 8'(((j[k] + 1) / ft) % 256);
        end
    endtask

    // Model advances on the same edges the DUT sees, including the asynchronous reset edge.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NI; k++) model_step(k);
    end

    // ---------------- timing trackers (hand-derived interval pins) ----------------
    int since_fs  [NI] = '{-1, -1};
    int since_vde [NI] = '{-1, -1};
    int hs_run    [NI] = '{0, 0};
    int vs_run    [NI] = '{0, 0};
    bit prev_vde  [NI] = '{1'b0, 1'b0};

    task automatic track(input int k, input obs_t g);
        int ht, vt;
        bit hs_act, vs_act;
        ht = HA[k] + HF[k] + HS[k] + HB[k];
        vt = VA[k] + VF[k] + VS[k] + VB[k];
        if (j[k] < 0) begin
            since_fs[k]  = -1;
            since_vde[k] = -1;
            hs_run[k]    = 0;
            vs_run[k]    = 0;
            prev_vde[k]  = 1'b0;
            return;
        end
        hs_act = (g.hs == HP[k]);
        vs_act = (g.vs == VP[k]);
        if (since_fs[k] >= 0) since_fs[k]++;
        if (since_vde[k] >= 0) since_vde[k]++;
        if (g.vde && !prev_vde[k]) since_vde[k] = 0;
        prev_vde[k] = g.vde;
        if (g.fs) begin
            if (since_fs[k] > 0) check("fs_period", 64'(since_fs[k]), 64'(ht * vt));
            since_fs[k] = 0;
        end
        if (hs_act) begin
            if (hs_run[k] == 0 && since_vde[k] >= 0 && since_vde[k] < ht)
                check("hs_start", 64'(since_vde[k]), 64'(HA[k] + HF[k]));
            hs_run[k]++;
        end else if (hs_run[k] > 0) begin
            check("hs_width", 64'(hs_run[k]), 64'(HS[k]));
            hs_run[k] = 0;
        end
        if (vs_act) begin
            if (vs_run[k] == 0 && since_fs[k] >= 0)
                check("vs_start", 64'(since_fs[k]), 64'((VA[k] + VF[k]) * ht));
            vs_run[k]++;
        end else if (vs_run[k] > 0) begin
            check("vs_width", 64'(vs_run[k]), 64'(VS[k] * ht));
            vs_run[k] = 0;
        end
    endtask

    // Compare process: every cycle, both instances, against the model.
    always @(negedge clk) begin
        obs_t got;
        for (int k = 0; k < NI; k++) begin
            got = (k == 0) ? obs_a : obs_b;
            check((k == 0) ? "model_a" : "model_b", 64'(got), 64'(expv[k]));
            track(k, got);
        end
    end

    // ---------------- stimulus ----------------
    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        adv(3);
        check("rst_hs_a", 64'(hs_a), 64'(1));
        check("rst_vs_a", 64'(vs_a), 64'(1));
        check("rst_vde_a", 64'(vde_a), 64'(0));
        check("rst_rgb_a", 64'({r_a, g_a, b_a}), 64'(0));
        check("rst_fc_a", 64'(fc_a), 64'(0));
        check("rst_hs_b", 64'(hs_b), 64'(0));

        rst = 1'b0;
        adv(1);                                            // position 0
        check("first_fs_a", 64'(fs_a), 64'(1));
        check("first_fs_b", 64'(fs_b), 64'(1));
        check("first_rgb_a", 64'({r_a, g_a, b_a}), 64'h0FFFFFF);
        adv(8);                                            // x=8 -> yellow bar
        check("bar_x8", 64'({r_a, g_a, b_a}), 64'h0FFFF00);
        adv(47);                                           // x=55 -> blue bar
        check("bar_x55", 64'({r_a, g_a, b_a}), 64'h00000FF);
        adv(8);                                            // x=63 -> black bar, still active
        check("bar_x63", 64'({r_a, g_a, b_a}), 64'h0000000);
        check("bar_x63_vde", 64'(vde_a), 64'(1));
        adv(1);                                            // x=64 blanking
        check("blank_vde", 64'(vde_a), 64'(0));
        check("blank_rgb", 64'({r_a, g_a, b_a}), 64'h0);

        adv(245 - 64);                                     // y=3 of first frame
        sel   = 3'd3;
        solid = 24'h123456;
        adv(455 - 245);                                    // y=5 x=55 same frame
        check("bars_hold", 64'({r_a, g_a, b_a}), 64'h00000FF);
        adv(1050 - 455);                                   // next frame y=2 x=10
        check("solid_next", 64'({r_a, g_a, b_a}), 64'h0123456);

        for (int s = 0; s < 12; s++) begin
            sel   = 3'($urandom_range(0, 7));
            solid = 24'($urandom);
            adv(int'($urandom_range(200, 2000)));
            if ($urandom_range(0, 2) == 0) begin
                en = 1'b0;
                adv(int'($urandom_range(1, 10)));
                en = 1'b1;
            end
        end

        sel = 3'd5;                                        // moving bar over 20 frames of A
        adv(17600);

        en = 1'b0;
        adv(1);
        check("en_low_vde", 64'(vde_a), 64'(0));
        check("en_low_x", 64'(x_a), 64'(0));
        check("en_low_fc", 64'(fc_a), 64'(0));
        check("en_low_hs", 64'(hs_a), 64'(1));
        adv(9);
        en  = 1'b1;
        sel = 3'd2;
        adv(1);
        check("en_fs_a", 64'(fs_a), 64'(1));
        check("en_fs_b", 64'(fs_b), 64'(1));
        adv(17000);
        sel = 3'd4;
        adv(35838 - 17000);
        check("fc_b_255", 64'(fc_b), 64'(255));
        adv(1);
        check("fc_b_wrap", 64'(fc_b), 64'(0));
        check("fc_a_40", 64'(fc_a), 64'(40));

        adv(271);                                          // A frame 41, x=30 y=0
        check("pre_async_vde", 64'(vde_a), 64'(1));
        check("pre_async_x", 64'(x_a), 64'(30));
        #2;
        rst = 1'b1;
        #1;
        check("async_vde", 64'(vde_a), 64'(0));
        check("async_x", 64'(x_a), 64'(0));
        check("async_hs", 64'(hs_a), 64'(1));
        check("async_fc", 64'(fc_a), 64'(0));
        adv(3);
        rst = 1'b0;
        adv(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
